seven_segment_scan_controller: RTL

SEVEN_SEGMENT_SCAN_CONTROLLER -- requirements
Module: seven_segment_scan_controller

---
 rtl/seven_segment_scan_controller.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/seven_segment_scan_controller.sv
// Seven-segment scan controller: time-multiplexes four BCD digits onto one
// decoder, with dead time between digits, a double-buffered load interface and
// optional leading-zero blanking. All outputs are registered.
module seven_segment_scan_controller #(
    parameter int unsigned DWELL = 1000,
    parameter int unsigned GAP   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    input  logic        blank_lz,
    output logic [3:0]  digit_code,
    output logic        digit_blank,
    output logic [3:0]  digit_en_n,
    output logic        frame_tick
);

    localparam int unsigned DWELL_W = 16;
    localparam int unsigned GAP_W   = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GAP_S = 2'd1;
    localparam logic [1:0] SHOW  = 2'd2;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP - 1);

    logic [1:0]         state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [15:0]        active_q, active_d;
    logic [15:0]        pending_q, pending_d;
    logic               pend_full_q, pend_full_d;
    logic               load_ready_q, load_ready_d;
    logic [3:0]         digit_code_q, digit_code_d;
    logic               digit_blank_q, digit_blank_d;
    logic [3:0]         digit_en_n_q, digit_en_n_d;
    logic               frame_tick_q, frame_tick_d;
    logic               frame_start_c;
    logic               accept_c;
    logic               transfer_c;

    // Select the nibble for a digit index.
    function automatic logic [3:0] nibble_of(input logic [15:0] v, input logic [1:0] i);
        logic [3:0] n;
        case (i)
            2'd0:    n = v[3:0];
            2'd1:    n = v[7:4];
            2'd2:    n = v[11:8];
            default: n = v[15:12];
        endcase
        return n;
    endfunction

    // A digit is a leading zero when it and every higher digit are zero; digit0 never is.
    function automatic logic leading_zero(input logic [15:0] v, input logic [1:0] i);
        logic z;
        case (i)
            2'd3:    z = (v[15:12] == 4'd0);
            2'd2:    z = (v[15:8] == 8'd0);
            2'd1:    z = (v[15:4] == 12'd0);
            default: z = 1'b0;
        endcase
        return z;
    endfunction

    // Scan sequencing, load buffering and registered output computation.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        dwell_cnt_d   = dwell_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        frame_start_c = 1'b0;

        if (!enable) begin
            state_d     = IDLE;
            idx_d       = 2'd0;
            dwell_cnt_d = '0;
            gap_cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d       = GAP_S;
                    idx_d         = 2'd0;
                    gap_cnt_d     = '0;
                    dwell_cnt_d   = '0;
                    frame_start_c = 1'b1;
                end
                GAP_S: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d     = SHOW;
                        gap_cnt_d   = '0;
                        dwell_cnt_d = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
                SHOW: begin
                    if (dwell_cnt_q == DWELL_LAST) begin
                        state_d       = GAP_S;
                        idx_d         = idx_q + 2'd1;
                        dwell_cnt_d   = '0;
                        gap_cnt_d     = '0;
                        frame_start_c = (idx_q == 2'd3);
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                    end
                end
                default: begin
                    state_d     = IDLE;
                    idx_d       = 2'd0;
                    dwell_cnt_d = '0;
                    gap_cnt_d   = '0;
                end
            endcase
        end

        // Pending moves to active only on a frame boundary, so a frame never tears.
        accept_c   = load_valid && load_ready_q;
        transfer_c = frame_start_c && pend_full_q;
        active_d   = transfer_c ? pending_q : active_q;
        pending_d  = accept_c ? load_data : pending_q;
        if (accept_c) begin
            pend_full_d = 1'b1;
        end else if (transfer_c) begin
            pend_full_d = 1'b0;
        end else begin
            pend_full_d = pend_full_q;
        end
        load_ready_d = !pend_full_d;

        frame_tick_d  = frame_start_c;
        digit_en_n_d  = (state_d == SHOW) ? ~(4'b0001 << idx_d) : 4'b1111;
        digit_code_d  = nibble_of(active_d, idx_d);
        digit_blank_d = blank_lz && leading_zero(active_d, idx_d);
    end

    // State, buffer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= 2'd0;
            dwell_cnt_q   <= '0;
            gap_cnt_q     <= '0;
            active_q      <= 16'h0000;
            pending_q     <= 16'h0000;
            pend_full_q   <= 1'b0;
            load_ready_q  <= 1'b1;
            digit_code_q  <= 4'd0;
            digit_blank_q <= 1'b0;
            digit_en_n_q  <= 4'b1111;
            frame_tick_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            dwell_cnt_q   <= dwell_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            pend_full_q   <= pend_full_d;
            load_ready_q  <= load_ready_d;
            digit_code_q  <= digit_code_d;
            digit_blank_q <= digit_blank_d;
            digit_en_n_q  <= digit_en_n_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign load_ready  = load_ready_q;
    assign digit_code  = digit_code_q;
    assign digit_blank = digit_blank_q;
    assign digit_en_n  = digit_en_n_q;
    assign frame_tick  = frame_tick_q;

endmodule
